// File: rtl/neo_pkg.sv
// neo_pkg: shared definitions for the NEO frame sequencer and datapath.
//   state_e        : sequencer state encoding (2-bit)
//   PRIME_CNT_DEF  : default number of window-fill samples whose outputs are discarded
package neo_pkg;

  localparam int unsigned PRIME_CNT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/neo_write_counter.sv
// neo_write_counter: result address register plus scheduled-write counter.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : reload address with BASE_ADDR and zero the write count (wins over adv/sched)
//   sched      : one write has been scheduled this cycle
//   adv        : one write is issued this cycle; address moves to the next slot
//   addr       : current write address (registered)
//   last_c     : the next scheduled write is the final one of the frame (combinational)
module neo_write_counter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sched,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  // One extra bit so a full 2**ADDR_W frame does not overflow the count.
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  // Address advances on issued writes; count advances on scheduled writes.
  always_comb begin
    addr_d   = addr_q;
    wr_cnt_d = wr_cnt_q;
    if (clear) begin
      addr_d   = ADDR_W'(BASE_ADDR);
      wr_cnt_d = '0;
    end else begin
      if (adv) begin
        addr_d = addr_q + ADDR_W'(1);
      end
      if (sched) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= ADDR_W'(BASE_ADDR);
      wr_cnt_q <= '0;
    end else begin
      addr_q   <= addr_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign addr   = addr_q;
  assign last_c = (wr_cnt_q == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/neo_frame_sequencer.sv
// neo_frame_sequencer: runs the NEO datapath for one frame at a time.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : frame request, only looked at in IDLE
//   abort      : synchronous abandon of the current frame
//   in_valid   : sample source has data
//   in_ready   : sample accepted this cycle (combinational)
//   full       : result memory cannot take new results (almost-full by one)
//   dp_clr     : datapath window clear, asserted in the IDLE cycle that starts a frame
//   dp_start   : datapath shift/compute strobe, equal to accept (combinational)
//   mem_we     : result write strobe, one cycle after each RUN accept
//   mem_addr   : result write address
//   busy       : frame in progress (PRIME or RUN)
//   done       : one-cycle pulse together with the last write
//   frame_cnt  : completed frames, wraps at 256
module neo_frame_sequencer
  import neo_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned PRIME_CNT = PRIME_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              full,
  output logic              dp_clr,
  output logic              dp_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  // PRIME_CNT is expected to be at least 1.
  localparam int unsigned PC_W = $clog2(PRIME_CNT + 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] prime_cnt_q, prime_cnt_d;
  logic            mem_we_q, mem_we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;

  logic active;
  logic accept;
  logic wc_clear;
  logic wc_sched;
  logic wc_last;

  // Handshake: abort and full both block new samples in the same cycle.
  assign active   = (state_q == PRIME) || (state_q == RUN);
  assign in_ready = active & ~full & ~abort;
  assign accept   = in_valid & in_ready;
  assign dp_start = accept;

  // Next-state and control decode.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    mem_we_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    dp_clr      = 1'b0;
    wc_clear    = 1'b0;
    wc_sched    = 1'b0;

    case (state_q)
      IDLE: begin
        wc_clear    = 1'b1;
        prime_cnt_d = '0;
        if (enable) begin
          dp_clr  = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (accept) begin
          if (prime_cnt_q == PC_W'(PRIME_CNT - 1)) begin
            prime_cnt_d = '0;
            state_d     = RUN;
          end else begin
            prime_cnt_d = prime_cnt_q + PC_W'(1);
          end
        end
      end
      RUN: begin
        if (accept) begin
          // Datapath registers its result on this edge; write it next cycle.
          mem_we_d = 1'b1;
          wc_sched = 1'b1;
          if (wc_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        wc_clear = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops the frame; a write already registered still goes out this cycle.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      prime_cnt_d = '0;
      mem_we_d    = 1'b0;
      wc_clear    = 1'b1;
      wc_sched    = 1'b0;
    end

    if (state_d == DONE) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    busy_d = (state_d == PRIME) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prime_cnt_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Address follows issued writes, so it holds the slot being written while mem_we is high.
  neo_write_counter #(
    .ADDR_W    (ADDR_W),
    .FRAME_LEN (FRAME_LEN),
    .BASE_ADDR (BASE_ADDR)
  ) u_write_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (wc_clear),
    .sched  (wc_sched),
    .adv    (mem_we_q),
    .addr   (mem_addr),
    .last_c (wc_last)
  );

  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule
